popcount_pipe: RTL and testbench



---
 rtl/popcount_pipe.sv | 159 +++++++++++++++
 tb/tb_popcount_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_pipe.sv
// Pipelined popcount over an IN_SIZE-bit word with valid/ready on both sides
// and an optional saturating per-frame accumulator on the output stage.
module popcount_pipe #(
  parameter int unsigned IN_SIZE      = 64,
  parameter int unsigned LEVELS       = $clog2(IN_SIZE),
  parameter int unsigned STAGE_LEVELS = 2,
  parameter int unsigned ACC_SIZE     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_SIZE-1:0]  in_data,
  input  logic                in_last,
  input  logic                acc_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEVELS:0]     out_count,
  output logic [ACC_SIZE-1:0] out_acc,
  output logic                out_last,
  output logic                out_acc_sat
);

  localparam int unsigned N = 1 << LEVELS;

  logic en;
  logic out_valid_q, out_valid_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Level k holds N>>k sums of k+1 bits; a register follows every
  // STAGE_LEVELS-th level and the final level, all sharing one enable.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned NK = N >> k;
    logic [k:0] node [NK];
    logic       vld;
    logic       last;
    logic       acc;

    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < NK; i++) begin : g_bit
        if (i < IN_SIZE) begin : g_data
          assign node[i] = in_data[i];
        end else begin : g_pad
          assign node[i] = 1'b0;
        end
      end
      assign vld  = in_valid;
      assign last = in_last;
      assign acc  = acc_en;
    end else begin : g_add
      logic [k:0] sum [NK];
      for (genvar i = 0; i < NK; i++) begin : g_pair
        assign sum[i] = {1'b0, g_lvl[k-1].node[2*i]} + {1'b0, g_lvl[k-1].node[2*i+1]};
      end
      if ((k % STAGE_LEVELS) == 0 || k == LEVELS) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            node <= '{default: '0};
            vld  <= 1'b0;
            last <= 1'b0;
            acc  <= 1'b0;
          end else if (en) begin
            node <= sum;
            vld  <= g_lvl[k-1].vld;
            last <= g_lvl[k-1].last;
            acc  <= g_lvl[k-1].acc;
          end
        end
      end else begin : g_comb
        assign node = sum;
        assign vld  = g_lvl[k-1].vld;
        assign last = g_lvl[k-1].last;
        assign acc  = g_lvl[k-1].acc;
      end
    end
  end

  logic [LEVELS:0]     tree_cnt;
  logic                tree_vld, tree_last, tree_acc;
  logic [ACC_SIZE:0]   sum_full;
  logic [ACC_SIZE-1:0] sum_sat;
  logic                ovf;

  assign tree_cnt  = g_lvl[LEVELS].node[0];
  assign tree_vld  = g_lvl[LEVELS].vld;
  assign tree_last = g_lvl[LEVELS].last;
  assign tree_acc  = g_lvl[LEVELS].acc;

  logic [LEVELS:0]     count_q, count_d;
  logic [ACC_SIZE-1:0] acc_out_q, acc_out_d;
  logic                last_q, last_d;
  logic                sat_out_q, sat_out_d;
  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic                sat_q, sat_d;

  always_comb begin
    sum_full    = {1'b0, acc_q} + (ACC_SIZE+1)'(tree_cnt);
    ovf         = sum_full[ACC_SIZE];
    sum_sat     = ovf ? '1 : sum_full[ACC_SIZE-1:0];
    out_valid_d = out_valid_q;
    count_d     = count_q;
    acc_out_d   = acc_out_q;
    last_d      = last_q;
    sat_out_d   = sat_out_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    if (en) begin
      out_valid_d = tree_vld;
      if (tree_vld) begin
        count_d = tree_cnt;
        last_d  = tree_last;
        if (tree_acc) begin
          acc_out_d = sum_sat;
          sat_out_d = sat_q | ovf;
          acc_d     = tree_last ? '0 : sum_sat;
          sat_d     = tree_last ? 1'b0 : (sat_q | ovf);
        end else begin
          // Non-accumulating beats report their own count and leave the
          // frame state alone unless they close the frame.
          acc_out_d = ACC_SIZE'(tree_cnt);
          sat_out_d = 1'b0;
          if (tree_last) begin
            acc_d = '0;
            sat_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      count_q     <= '0;
      acc_out_q   <= '0;
      last_q      <= 1'b0;
      sat_out_q   <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      acc_out_q   <= acc_out_d;
      last_q      <= last_d;
      sat_out_q   <= sat_out_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_count   = count_q;
  assign out_acc     = acc_out_q;
  assign out_last    = last_q;
  assign out_acc_sat = sat_out_q;

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench for popcount_pipe: three configurations (64/16, 64/8-bit acc, 13-bit
// with one level per stage) driven one at a time through a shared scoreboard.
module tb_popcount_pipe;

  typedef struct {
    int          sel;
    logic [63:0] data;
    bit          last;
    bit          acc;
    int          cnt;
    int          accv;
    bit          lst;
    bit          sat;
  } vec_t;

  typedef struct {
    int sel;
    int cnt;
    int accv;
    bit lst;
    bit sat;
    int lat;
    int t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, acc_en, out_ready;
  logic [63:0] in_data;
  int          sel;

  logic        v0, v1, v2, rdy0, rdy1, rdy2, rdy_m;
  logic        ov0, ov1, ov2, ol0, ol1, ol2, os0, os1, os2;
  logic [6:0]  c0, c1;
  logic [4:0]  c2;
  logic [15:0] a0, a2;
  logic [7:0]  a1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   popped = 0;
  bit   rand_rdy = 1'b0;
  bit   chk_stable = 1'b0;
  exp_t sb[$];

  assign v0 = in_valid && (sel == 0);
  assign v1 = in_valid && (sel == 1);
  assign v2 = in_valid && (sel == 2);
  assign rdy_m = (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;

  popcount_pipe #(.IN_SIZE(64), .STAGE_LEVELS(2), .ACC_SIZE(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .acc_en(acc_en), .out_valid(ov0), .out_ready(out_ready),
    .out_count(c0), .out_acc(a0), .out_last(ol0), .out_acc_sat(os0));

  popcount_pipe #(.IN_SIZE(64), .STAGE_LEVELS(2), .ACC_SIZE(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .acc_en(acc_en), .out_valid(ov1), .out_ready(out_ready),
    .out_count(c1), .out_acc(a1), .out_last(ol1), .out_acc_sat(os1));

  popcount_pipe #(.IN_SIZE(13), .STAGE_LEVELS(1), .ACC_SIZE(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(in_data[12:0]),
    .in_last(in_last), .acc_en(acc_en), .out_valid(ov2), .out_ready(out_ready),
    .out_count(c2), .out_acc(a2), .out_last(ol2), .out_acc_sat(os2));

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ~2/3 duty random backpressure when enabled
  initial forever begin
    @(negedge clk);
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
  end

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endfunction

  function automatic void get_out(input int j, output logic ov, output logic [63:0] c,
                                  output logic [63:0] a, output logic l, output logic s);
    case (j)
      0: begin ov = ov0; c = 64'(c0); a = 64'(a0); l = ol0; s = os0; end
      1: begin ov = ov1; c = 64'(c1); a = 64'(a1); l = ol1; s = os1; end
      default: begin ov = ov2; c = 64'(c2); a = 64'(a2); l = ol2; s = os2; end
    endcase
  endfunction

  // Output monitor: pops the scoreboard on each handshake, and while
  // chk_stable is set verifies d0 outputs hold across stalled cycles.
  initial begin
    logic        ovj, lj, sj, pl, ps;
    logic [63:0] cj, aj, pc, pa;
    bit          prev_stall;
    exp_t        e;
    prev_stall = 1'b0;
    pc = '0; pa = '0; pl = 1'b0; ps = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        for (int j = 0; j < 3; j++) begin
          get_out(j, ovj, cj, aj, lj, sj);
          if (ovj && out_ready) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious_output dut%0d: got out_valid 1, expected no beat", j);
            end else begin
              e = sb.pop_front();
              popped++;
              chk("dut_sel", 64'(j), 64'(e.sel));
              chk("out_count", cj, 64'(e.cnt));
              chk("out_acc", aj, 64'(e.accv));
              chk("out_last", 64'(lj), 64'(e.lst));
              chk("out_acc_sat", 64'(sj), 64'(e.sat));
              if (e.lat != 0) chk("latency", 64'(cyc - e.t), 64'(e.lat));
            end
          end
        end
        if (chk_stable) begin
          if (prev_stall) begin
            chk("stall_valid", 64'(ov0), 64'd1);
            chk("stall_count", 64'(c0), pc);
            chk("stall_acc", 64'(a0), pa);
            chk("stall_last", 64'(ol0), 64'(pl));
            chk("stall_sat", 64'(os0), 64'(ps));
          end
          prev_stall = ov0 && !out_ready;
          pc = 64'(c0); pa = 64'(a0); pl = ol0; ps = os0;
        end else begin
          prev_stall = 1'b0;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic send(input vec_t v, input int lat);
    bit ok;
    bit rdy;
    int t;
    exp_t e;
    ok = 1'b0;
    t = 0;
    @(negedge clk);
    #1;
    sel = v.sel; in_data = v.data; in_last = v.last; acc_en = v.acc; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      rdy = rdy_m;
      t = cyc;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    #1;
    in_valid = 1'b0;
    if (ok) begin
      e = '{v.sel, v.cnt, v.accv, v.lst, v.sat, lat, t};
      sb.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got no in_ready in 200 cycles, expected accept", v.sel);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  localparam int NV = 21;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    vec_t tbl [NV];
    vec_t v;
    int   m_acc, s, n, base;
    bit   m_sat, ovf;

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; acc_en = 1'b0;
    in_data = '0; sel = 0; out_ready = 1'b1;

    //           sel data                    last acc  cnt accv lst sat
    tbl[0]  = '{0, 64'h0,                    0, 0,   0,   0, 0, 0};
    tbl[1]  = '{0, ONES,                     0, 0,  64,  64, 0, 0};
    tbl[2]  = '{0, 64'h8000_0000_0000_0001,  0, 0,   2,   2, 0, 0};
    tbl[3]  = '{0, ONES,                     0, 1,  64,  64, 0, 0};
    tbl[4]  = '{0, ONES,                     0, 1,  64, 128, 0, 0};
    tbl[5]  = '{0, ONES,                     0, 1,  64, 192, 0, 0};
    tbl[6]  = '{0, ONES,                     1, 1,  64, 256, 1, 0};
    tbl[7]  = '{0, 64'h3,                    0, 1,   2,   2, 0, 0};
    tbl[8]  = '{0, 64'h3,                    1, 0,   2,   2, 1, 0};
    tbl[9]  = '{0, 64'h1,                    1, 1,   1,   1, 1, 0};
    tbl[10] = '{1, ONES,                     0, 1,  64,  64, 0, 0};
    tbl[11] = '{1, ONES,                     0, 1,  64, 128, 0, 0};
    tbl[12] = '{1, ONES,                     0, 1,  64, 192, 0, 0};
    tbl[13] = '{1, ONES,                     0, 1,  64, 255, 0, 1};
    tbl[14] = '{1, ONES,                     1, 1,  64, 255, 1, 1};
    tbl[15] = '{1, ONES,                     0, 1,  64,  64, 0, 0};
    tbl[16] = '{1, ONES,                     1, 0,  64,  64, 1, 0};
    tbl[17] = '{2, 64'h1FFF,                 0, 0,  13,  13, 0, 0};
    tbl[18] = '{2, 64'h1000,                 0, 0,   1,   1, 0, 0};
    tbl[19] = '{2, 64'h1FFF,                 1, 1,  13,  13, 1, 0};
    tbl[20] = '{2, 64'h0,                    0, 0,   0,   0, 0, 0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_out_count", 64'(c0), 64'd0);
    chk("rst_out_acc", 64'(a0), 64'd0);
    chk("rst_out_last", 64'(ol0), 64'd0);
    chk("rst_out_acc_sat", 64'(os0), 64'd0);
    chk("rst_out_valid_d1", 64'(ov1), 64'd0);
    chk("rst_out_valid_d2", 64'(ov2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 64'(rdy0), 64'd1);

    for (int i = 0; i < NV; i++) begin
      if (i > 0 && tbl[i].sel != tbl[i-1].sel) drain();
      send(tbl[i], (tbl[i].sel == 2) ? 5 : 4);
    end
    drain();

    // Build a partial frame of 100, then stall three beats inside the pipe.
    send('{0, ONES, 0, 1, 64, 64, 0, 0}, 4);
    send('{0, 64'h0000_000F_FFFF_FFFF, 0, 1, 36, 100, 0, 0}, 4);
    drain();
    out_ready = 1'b0;
    repeat (3) send('{0, ONES, 0, 1, 64, 0, 0, 0}, 0);
    n = 0;
    while (!ov0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("inflight_out_valid", 64'(ov0), 64'd1);
    chk("inflight_out_acc", 64'(a0), 64'd164);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov0), 64'd0);
    chk("midrst_out_acc", 64'(a0), 64'd0);
    chk("midrst_out_count", 64'(c0), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_midrst", 64'(rdy0), 64'd1);
    out_ready = 1'b1;
    send('{0, 64'h1, 1, 1, 1, 1, 1, 0}, 4);
    drain();

    // Randomised stream under gapped valid and random backpressure.
    chk_stable = 1'b1;
    rand_rdy = 1'b1;
    base = popped;
    m_acc = 0;
    m_sat = 1'b0;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      v.sel  = 0;
      v.data = {$urandom(), $urandom()};
      v.last = ($urandom_range(0, 3) == 0);
      v.acc  = ($urandom_range(0, 1) == 1);
      v.cnt  = $countones(v.data);
      v.lst  = v.last;
      if (v.acc) begin
        s   = m_acc + v.cnt;
        ovf = (s > 65535);
        if (ovf) s = 65535;
        v.accv = s;
        v.sat  = m_sat | ovf;
        m_acc  = v.last ? 0 : s;
        m_sat  = v.last ? 1'b0 : v.sat;
      end else begin
        v.accv = v.cnt;
        v.sat  = 1'b0;
        if (v.last) begin
          m_acc = 0;
          m_sat = 1'b0;
        end
      end
      send(v, 0);
    end
    drain();
    chk("bp_beats_delivered", 64'(popped - base), 64'd20);
    rand_rdy = 1'b0;
    chk_stable = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
